// File: rtl/pipelined_slot_crossbar_v3.sv
// pipelined_slot_crossbar_v3
// Routes SRC_SLOTS source words to DST_SLOTS destinations. Each destination
// owns a binary mux tree that resolves one select bit per level, LSB first.
// A register follows every REG_STRIDE levels (and always the last level).
// Select, valid and select-error bits travel with the data through the
// same registers, so every level only ever sees its own beat's control.
module pipelined_slot_crossbar_v3 #(
    parameter int DATA_SIZE    = 512,
    parameter int SRC_SLOTS    = 32,
    parameter int DST_SLOTS    = 32,
    parameter int REG_STRIDE   = 1,
    parameter bit ZERO_INVALID = 1,
    localparam int SW          = $clog2(SRC_SLOTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           in_valid,
    input  logic [SRC_SLOTS*DATA_SIZE-1:0] in_data,
    input  logic [DST_SLOTS*SW-1:0]        dst_sel,
    input  logic [DST_SLOTS-1:0]           dst_en,
    output logic [DST_SLOTS-1:0]           out_valid,
    output logic [DST_SLOTS*DATA_SIZE-1:0] out_data,
    output logic [DST_SLOTS*SW-1:0]        out_sel,
    output logic [DST_SLOTS-1:0]           sel_err,
    output logic                           pipe_empty
);

    localparam int LEVELS = SW;
    localparam int LEAVES = 1 << LEVELS;
    localparam int NSTG   = (LEVELS + REG_STRIDE - 1) / REG_STRIDE;
    localparam int CW     = $clog2(NSTG + 1);
    localparam int LAST   = LEVELS - 1;

    genvar gi, gk, gn;

    // Sources padded up to a power of two; padded leaves read as zero, which
    // is also what an out-of-range select ends up routing.
    logic [LEAVES*DATA_SIZE-1:0] w_leaves;

    if (LEAVES > SRC_SLOTS) begin : g_pad
        assign w_leaves = {{((LEAVES - SRC_SLOTS) * DATA_SIZE){1'b0}}, in_data};
    end else begin : g_nopad
        assign w_leaves = in_data;
    end

    for (gi = 0; gi < DST_SLOTS; gi++) begin : g_dst
        logic [SW-1:0] w_sel0;
        logic          w_vld0;
        logic          w_err0;

        assign w_sel0 = dst_sel[gi*SW +: SW];
        assign w_vld0 = in_valid & dst_en[gi];
        // The error is a property of a requested beat, so it pulses with it.
        assign w_err0 = w_vld0 & (int'(w_sel0) >= SRC_SLOTS);

        for (gk = 0; gk < LEVELS; gk++) begin : g_lvl
            localparam int NIN    = LEAVES >> gk;
            localparam int NOUT   = NIN / 2;
            localparam bit IS_REG = (((gk + 1) % REG_STRIDE) == 0) || (gk == LEVELS - 1);

            logic [NIN*DATA_SIZE-1:0]  w_din;
            logic [SW-1:0]             w_sel_i;
            logic                      w_vld_i;
            logic                      w_err_i;
            logic [NOUT*DATA_SIZE-1:0] w_mux;
            logic [NOUT*DATA_SIZE-1:0] w_dq;
            logic [SW-1:0]             w_sel_q;
            logic                      w_vld_q;
            logic                      w_err_q;

            if (gk == 0) begin : g_src
                assign w_din   = w_leaves;
                assign w_sel_i = w_sel0;
                assign w_vld_i = w_vld0;
                assign w_err_i = w_err0;
            end else begin : g_chain
                assign w_din   = g_lvl[gk-1].w_dq;
                assign w_sel_i = g_lvl[gk-1].w_sel_q;
                assign w_vld_i = g_lvl[gk-1].w_vld_q;
                assign w_err_i = g_lvl[gk-1].w_err_q;
            end

            // Pairs (2n, 2n+1) differ only in select bit gk.
            for (gn = 0; gn < NOUT; gn++) begin : g_node
                assign w_mux[gn*DATA_SIZE +: DATA_SIZE] = w_sel_i[gk]
                    ? w_din[(2*gn+1)*DATA_SIZE +: DATA_SIZE]
                    : w_din[(2*gn)*DATA_SIZE +: DATA_SIZE];
            end

            if (IS_REG) begin : g_reg
                logic [NOUT*DATA_SIZE-1:0] r_data;
                logic [SW-1:0]             r_sel;
                logic                      r_vld;
                logic                      r_err;

                // Stage register: reset drops the beat, en=0 freezes it.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_data <= '0;
                        r_sel  <= '0;
                        r_vld  <= 1'b0;
                        r_err  <= 1'b0;
                    end else if (en) begin
                        r_data <= w_mux;
                        r_sel  <= w_sel_i;
                        r_vld  <= w_vld_i;
                        r_err  <= w_err_i;
                    end
                end

                assign w_dq    = r_data;
                assign w_sel_q = r_sel;
                assign w_vld_q = r_vld;
                assign w_err_q = r_err;
            end else begin : g_comb
                assign w_dq    = w_mux;
                assign w_sel_q = w_sel_i;
                assign w_vld_q = w_vld_i;
                assign w_err_q = w_err_i;
            end
        end

        assign out_valid[gi]          = g_lvl[LAST].w_vld_q;
        assign out_sel[gi*SW +: SW]   = g_lvl[LAST].w_sel_q;
        assign sel_err[gi]            = g_lvl[LAST].w_err_q;

        if (ZERO_INVALID) begin : g_zero
            assign out_data[gi*DATA_SIZE +: DATA_SIZE] =
                g_lvl[LAST].w_vld_q ? g_lvl[LAST].w_dq : '0;
        end else begin : g_raw
            assign out_data[gi*DATA_SIZE +: DATA_SIZE] = g_lvl[LAST].w_dq;
        end
    end

    // Occupancy: a beat counts while any of its destinations is valid,
    // from the cycle after entry until it leaves the output register.
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          w_enter;
    logic          w_exit;

    assign w_enter = in_valid & (|dst_en);
    assign w_exit  = |out_valid;

    // Next occupancy: simultaneous entry and exit cancel out.
    always_comb begin
        w_count_next = r_count;
        if (w_enter && !w_exit) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_enter && w_exit) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Occupancy register advances only with the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_count_next;
        end
    end

    assign pipe_empty = (r_count == '0);

endmodule

// File: tb/tb_pipelined_slot_crossbar_v3.sv
// Bench for pipelined_slot_crossbar_v3: instance A (32x32, stride 1,
// zeroed invalid lanes, L=5) and instance B (20 sources, 8 destinations,
// stride 2, raw tree data on invalid lanes, L=3).
module tb_pipelined_slot_crossbar_v3;
    localparam int DW = 16;
    localparam int AS = 32, AD = 32, AW = 5, AL = 5;
    localparam int BS = 20, BD = 8,  BW = 5, BL = 3;

    logic clk, rst, en;

    logic               a_in_valid;
    logic [AS*DW-1:0]   a_in_data;
    logic [AD*AW-1:0]   a_dst_sel;
    logic [AD-1:0]      a_dst_en;
    logic [AD-1:0]      a_out_valid;
    logic [AD*DW-1:0]   a_out_data;
    logic [AD*AW-1:0]   a_out_sel;
    logic [AD-1:0]      a_sel_err;
    logic               a_pipe_empty;

    logic               b_in_valid;
    logic [BS*DW-1:0]   b_in_data;
    logic [BD*BW-1:0]   b_dst_sel;
    logic [BD-1:0]      b_dst_en;
    logic [BD-1:0]      b_out_valid;
    logic [BD*DW-1:0]   b_out_data;
    logic [BD*BW-1:0]   b_out_sel;
    logic [BD-1:0]      b_sel_err;
    logic               b_pipe_empty;

    pipelined_slot_crossbar_v3 #(
        .DATA_SIZE(DW), .SRC_SLOTS(AS), .DST_SLOTS(AD), .REG_STRIDE(1), .ZERO_INVALID(1'b1)
    ) u_a (
        .clk(clk), .rst(rst), .en(en), .in_valid(a_in_valid), .in_data(a_in_data),
        .dst_sel(a_dst_sel), .dst_en(a_dst_en), .out_valid(a_out_valid),
        .out_data(a_out_data), .out_sel(a_out_sel), .sel_err(a_sel_err),
        .pipe_empty(a_pipe_empty)
    );

    pipelined_slot_crossbar_v3 #(
        .DATA_SIZE(DW), .SRC_SLOTS(BS), .DST_SLOTS(BD), .REG_STRIDE(2), .ZERO_INVALID(1'b0)
    ) u_b (
        .clk(clk), .rst(rst), .en(en), .in_valid(b_in_valid), .in_data(b_in_data),
        .dst_sel(b_dst_sel), .dst_en(b_dst_en), .out_valid(b_out_valid),
        .out_data(b_out_data), .out_sel(b_out_sel), .sel_err(b_sel_err),
        .pipe_empty(b_pipe_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic             in_valid;
        logic [AD-1:0]    dst_en;
        logic [AD*AW-1:0] sel;
        logic [AS*DW-1:0] data;
        logic [AD-1:0]    exp_valid;
        logic [AD*DW-1:0] exp_data;
    } vec_t;

    typedef struct {
        logic [AD-1:0]    v;
        logic [AD*DW-1:0] d;
        logic [AD*AW-1:0] s;
    } beat_t;

    vec_t  tbl[6];
    beat_t mq[$];

    // Expected view of one beat at the crossbar output, from the routing rule.
    function automatic beat_t route(input logic iv, input logic [AD-1:0] de,
                                    input logic [AD*AW-1:0] ds, input logic [AS*DW-1:0] di);
        beat_t b;
        int    idx;
        b.v = '0;
        b.d = '0;
        b.s = ds;
        for (int d = 0; d < AD; d++) begin
            idx = int'(ds[d*AW +: AW]);
            if (iv && de[d]) begin
                b.v[d] = 1'b1;
                b.d[d*DW +: DW] = di[idx*DW +: DW];
            end
        end
        return b;
    endfunction

    function automatic beat_t idle_beat();
        beat_t b;
        b.v = '0;
        b.d = '0;
        b.s = '0;
        return b;
    endfunction

    logic [AS*DW-1:0] ident_data;
    logic [AD*AW-1:0] ident_sel, rev_sel, bc_sel;
    logic [AD*DW-1:0] ident_out, rev_out, bc_out;
    logic [BD*DW-1:0] b_exp_data;
    logic [BD*BW-1:0] b_exp_sel;
    beat_t            exp_b;
    logic             any_v;

    initial begin
        // ---------------- stimulus tables ----------------
        for (int i = 0; i < AS; i++) ident_data[i*DW +: DW] = 16'(i + 256);
        for (int d = 0; d < AD; d++) begin
            ident_sel[d*AW +: AW] = 5'(d);
            rev_sel[d*AW +: AW]   = 5'(31 - d);
            bc_sel[d*AW +: AW]    = 5'd7;
            ident_out[d*DW +: DW] = 16'(d + 256);
            rev_out[d*DW +: DW]   = 16'(31 - d + 256);
            bc_out[d*DW +: DW]    = 16'h0107;
        end

        for (int r = 0; r < 6; r++) begin
            tbl[r].in_valid = 1'b1;
            tbl[r].dst_en   = '1;
            tbl[r].data     = ident_data;
            tbl[r].sel      = ident_sel;
        end
        tbl[1].sel = rev_sel;
        tbl[2].sel = bc_sel;
        tbl[3].dst_en = 32'h0000_00F0;
        tbl[4].in_valid = 1'b0;
        tbl[5].dst_en = $urandom;
        for (int i = 0; i < AS; i++) tbl[5].data[i*DW +: DW] = 16'($urandom);
        for (int d = 0; d < AD; d++) tbl[5].sel[d*AW +: AW] = 5'($urandom_range(0, 31));

        tbl[0].exp_valid = '1; tbl[0].exp_data = ident_out;
        tbl[1].exp_valid = '1; tbl[1].exp_data = rev_out;
        tbl[2].exp_valid = '1; tbl[2].exp_data = bc_out;
        for (int r = 3; r < 6; r++) begin
            exp_b = route(tbl[r].in_valid, tbl[r].dst_en, tbl[r].sel, tbl[r].data);
            tbl[r].exp_valid = exp_b.v;
            tbl[r].exp_data  = exp_b.d;
        end

        // ---------------- reset state ----------------
        rst = 1'b1; en = 1'b1;
        a_in_valid = 1'b0; a_in_data = ident_data; a_dst_sel = ident_sel; a_dst_en = '1;
        b_in_valid = 1'b0; b_in_data = '0; b_dst_sel = '0; b_dst_en = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_a_valid", 512'(a_out_valid), '0);
        chk("rst_a_data",  512'(a_out_data), '0);
        chk("rst_a_sel",   512'(a_out_sel), '0);
        chk("rst_a_err",   512'(a_sel_err), '0);
        chk("rst_a_empty", 512'(a_pipe_empty), 512'(1));
        chk("rst_b_valid", 512'(b_out_valid), '0);
        chk("rst_b_empty", 512'(b_pipe_empty), 512'(1));

        // ---------------- table-driven single beats on A ----------------
        for (int r = 0; r < 6; r++) begin
            a_in_valid = tbl[r].in_valid;
            a_dst_en   = tbl[r].dst_en;
            a_dst_sel  = tbl[r].sel;
            a_in_data  = tbl[r].data;
            tick();
            a_in_valid = 1'b0;
            repeat (AL - 1) tick();
            chk($sformatf("tbl%0d_valid", r), 512'(a_out_valid), 512'(tbl[r].exp_valid));
            chk($sformatf("tbl%0d_data", r),  512'(a_out_data),  512'(tbl[r].exp_data));
            chk($sformatf("tbl%0d_sel", r),   512'(a_out_sel),   512'(tbl[r].sel));
            chk($sformatf("tbl%0d_empty", r), 512'(a_pipe_empty), 512'(tbl[r].exp_valid == '0));
            tick();
            chk($sformatf("tbl%0d_valid_after", r), 512'(a_out_valid), '0);
            chk($sformatf("tbl%0d_empty_after", r), 512'(a_pipe_empty), 512'(1));
        end

        // ---------------- back-to-back reverse then broadcast ----------------
        a_dst_en = '1; a_in_data = ident_data;
        a_in_valid = 1'b1; a_dst_sel = rev_sel;
        tick();
        a_dst_sel = bc_sel;
        tick();
        a_in_valid = 1'b0;
        repeat (AL - 2) tick();
        chk("b2b_rev_valid", 512'(a_out_valid), 512'({AD{1'b1}}));
        chk("b2b_rev_data",  512'(a_out_data), 512'(rev_out));
        tick();
        chk("b2b_bc_valid", 512'(a_out_valid), 512'({AD{1'b1}}));
        chk("b2b_bc_data",  512'(a_out_data), 512'(bc_out));
        tick();
        chk("b2b_valid_after", 512'(a_out_valid), '0);
        chk("b2b_empty_after", 512'(a_pipe_empty), 512'(1));

        // ---------------- stall during flight and at the output ----------------
        a_dst_sel = ident_sel;
        for (int c = 0; c < 12; c++) begin
            logic vexp;
            vexp = (c >= 8) && (c <= 10);
            chk($sformatf("stall_c%0d_valid", c), 512'(a_out_valid), vexp ? 512'({AD{1'b1}}) : '0);
            chk($sformatf("stall_c%0d_data", c),  512'(a_out_data), vexp ? 512'(ident_out) : '0);
            chk($sformatf("stall_c%0d_empty", c), 512'(a_pipe_empty), 512'((c == 0) || (c == 11)));
            a_in_valid = (c == 0);
            en = !((c >= 2 && c <= 4) || c == 8 || c == 9);
            tick();
        end
        en = 1'b1;
        a_in_valid = 1'b0;

        // ---------------- non-power-of-two sources, range error (B) ----------------
        for (int i = 0; i < BS; i++) b_in_data[i*DW +: DW] = 16'(i + 512);
        for (int d = 0; d < BD; d++) b_dst_sel[d*BW +: BW] = 5'(d);
        b_dst_sel[0*BW +: BW] = 5'd19;
        b_dst_sel[1*BW +: BW] = 5'd25;
        b_dst_sel[2*BW +: BW] = 5'd3;
        b_dst_en = 8'hFB;
        b_exp_sel = b_dst_sel;
        b_exp_data = '0;
        for (int d = 3; d < BD; d++) b_exp_data[d*DW +: DW] = 16'(d + 512);
        b_exp_data[0*DW +: DW] = 16'h0213;
        b_exp_data[1*DW +: DW] = 16'h0000;
        b_exp_data[2*DW +: DW] = 16'h0203;
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        repeat (BL - 2) tick();
        chk("b_early_valid", 512'(b_out_valid), '0);
        chk("b_early_err",   512'(b_sel_err), '0);
        chk("b_early_empty", 512'(b_pipe_empty), '0);
        tick();
        chk("b_valid", 512'(b_out_valid), 512'(8'hFB));
        chk("b_err",   512'(b_sel_err), 512'(8'h02));
        chk("b_data",  512'(b_out_data), 512'(b_exp_data));
        chk("b_sel",   512'(b_out_sel), 512'(b_exp_sel));
        tick();
        chk("b_after_valid", 512'(b_out_valid), '0);
        chk("b_after_err",   512'(b_sel_err), '0);
        chk("b_after_data",  512'(b_out_data), 512'(b_exp_data));
        chk("b_after_empty", 512'(b_pipe_empty), 512'(1));

        // ---------------- reset mid-flight (A) ----------------
        a_dst_sel = ident_sel; a_dst_en = '1; a_in_data = ident_data;
        a_in_valid = 1'b1;
        repeat (3) tick();
        a_in_valid = 1'b0;
        chk("midrst_empty_before", 512'(a_pipe_empty), '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 4; c <= 14; c++) begin
            chk($sformatf("midrst_c%0d_valid", c), 512'(a_out_valid), '0);
            chk($sformatf("midrst_c%0d_empty", c), 512'(a_pipe_empty), 512'(1));
            tick();
        end

        // ---------------- randomized run against the model (A) ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mq.delete();
        repeat (AL) mq.push_back(idle_beat());
        for (int c = 0; c < 400; c++) begin
            exp_b = mq[0];
            any_v = 1'b0;
            foreach (mq[i]) if (mq[i].v != '0) any_v = 1'b1;
            chk($sformatf("rnd%0d_valid", c), 512'(a_out_valid), 512'(exp_b.v));
            chk($sformatf("rnd%0d_data", c),  512'(a_out_data), 512'(exp_b.d));
            chk($sformatf("rnd%0d_sel", c),   512'(a_out_sel), 512'(exp_b.s));
            chk($sformatf("rnd%0d_err", c),   512'(a_sel_err), '0);
            chk($sformatf("rnd%0d_empty", c), 512'(a_pipe_empty), 512'(!any_v));

            en  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 49) == 0);
            a_in_valid = ($urandom_range(0, 9) < 7);
            a_dst_en = ($urandom_range(0, 4) == 0) ? '0 : AD'($urandom);
            for (int d = 0; d < AD; d++) a_dst_sel[d*AW +: AW] = 5'($urandom_range(0, 31));
            for (int i = 0; i < AS; i++) a_in_data[i*DW +: DW] = 16'($urandom);

            if (rst) begin
                mq.delete();
                repeat (AL) mq.push_back(idle_beat());
            end else if (en) begin
                mq.delete(0);
                mq.push_back(route(a_in_valid, a_dst_en, a_dst_sel, a_in_data));
            end
            tick();
        end
        rst = 1'b0;
        en = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
